// File: rtl/ssd_capture.sv
// ssd_capture: recovers the four digits shown on a multiplexed, active-low
// seven-segment display by watching its segment and anode lines.
//
// The segment/anode bus is registered once, then must stay unchanged for
// SETTLE cycles before the selected digit is decoded into a shadow slot.
// Once all four digit slots have been captured, the shadows are published
// to digit0..3 and a new frame starts collecting.
//
// Parameters
//   SETTLE   cycles the bus must be stable before a capture (2..255)
//   TIMEOUT  cycles without any capture before valid drops
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   a..g         segment lines, active low (0 = lit)
//   an0..an3     anode enables, active low (0 = digit selected)
//   digit0..3    last published code per digit (0-F, 10 blank, 11 dash, 1F bad)
//   valid        published digits come from a frame within TIMEOUT
//   frame_done   one-cycle pulse when a frame is published
//   err_pattern  sticky: an undecodable segment pattern was captured
module ssd_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       an0,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       valid,
  output logic       frame_done,
  output logic       err_pattern
);

  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SETTLE_MAX = 8'(SETTLE);
  localparam logic [7:0]    SETTLE_HIT = 8'(SETTLE - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT);
  localparam logic [4:0]    CODE_BLANK = 5'h10;
  localparam logic [4:0]    CODE_BAD   = 5'h1F;

  typedef enum logic {SETTLING, HELD} state_t;

  state_t        state;
  logic [10:0]   w_raw;
  logic [10:0]   w_q;
  logic [10:0]   w_prev;
  logic [6:0]    pat;
  logic [3:0]    an_low;
  logic          changed;
  logic          one_low;
  logic [1:0]    k;
  logic [4:0]    code;
  logic          capture;
  logic [7:0]    cnt;
  logic [7:0]    cnt_next;
  logic [IW-1:0] idle;
  logic [IW-1:0] idle_next;
  logic [3:0]    seen;
  logic [4:0]    shadow [4];

  assign w_raw = {an3, an2, an1, an0, g, f, e, d, c, b, a};

  always_comb begin
    pat     = w_q[6:0];
    an_low  = ~w_q[10:7];
    changed = (w_q != w_prev);
    cnt_next = (cnt >= SETTLE_MAX) ? SETTLE_MAX : cnt + 8'd1;

    one_low = 1'b1;
    k       = 2'd0;
    case (an_low)
      4'b0001: k = 2'd0;
      4'b0010: k = 2'd1;
      4'b0100: k = 2'd2;
      4'b1000: k = 2'd3;
      default: one_low = 1'b0;
    endcase

    case (pat)
      7'h40:   code = 5'h00;
      7'h79:   code = 5'h01;
      7'h24:   code = 5'h02;
      7'h30:   code = 5'h03;
      7'h19:   code = 5'h04;
      7'h12:   code = 5'h05;
      7'h02:   code = 5'h06;
      7'h78:   code = 5'h07;
      7'h00:   code = 5'h08;
      7'h10:   code = 5'h09;
      7'h08:   code = 5'h0A;
      7'h03:   code = 5'h0B;
      7'h46:   code = 5'h0C;
      7'h21:   code = 5'h0D;
      7'h06:   code = 5'h0E;
      7'h0E:   code = 5'h0F;
      7'h7F:   code = CODE_BLANK;
      7'h3F:   code = 5'h11;
      default: code = CODE_BAD;
    endcase

    // Capture on the edge where the counter steps onto SETTLE-1; this places
    // the capture SETTLE edges after the bus value is first registered.
    capture = (state == SETTLING) && !changed && one_low && (cnt_next == SETTLE_HIT);

    if (capture)
      idle_next = '0;
    else if (idle == IDLE_MAX)
      idle_next = idle;
    else
      idle_next = idle + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SETTLING;
      w_q         <= '1;
      w_prev      <= '1;
      cnt         <= '0;
      idle        <= '0;
      seen        <= '0;
      digit0      <= CODE_BLANK;
      digit1      <= CODE_BLANK;
      digit2      <= CODE_BLANK;
      digit3      <= CODE_BLANK;
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= CODE_BLANK;
    end else begin
      w_q        <= w_raw;
      w_prev     <= w_q;
      cnt        <= changed ? '0 : cnt_next;
      idle       <= idle_next;
      frame_done <= 1'b0;

      case (state)
        SETTLING: if (capture) state <= HELD;
        HELD:     if (changed) state <= SETTLING;
        default:  state <= SETTLING;
      endcase

      if (capture) begin
        shadow[k] <= code;
        if (code == CODE_BAD) err_pattern <= 1'b1;
      end

      // Publishing reads the shadows as they were before this edge, so a
      // capture landing on the same edge belongs to the next frame.
      if (seen == 4'b1111) begin
        digit0     <= shadow[0];
        digit1     <= shadow[1];
        digit2     <= shadow[2];
        digit3     <= shadow[3];
        frame_done <= 1'b1;
        valid      <= 1'b1;
        seen       <= capture ? (4'b0001 << k) : '0;
      end else if (capture) begin
        seen[k] <= 1'b1;
      end

      if (idle_next == IDLE_MAX) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_capture.sv
module tb_ssd_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a, b, c, d, e, f, g;
  logic       an0, an1, an2, an3;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic       valid, frame_done, err_pattern;

  int errors = 0;
  int checks = 0;
  int fd_total = 0;
  int base;

  ssd_capture #(.SETTLE(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .valid(valid), .frame_done(frame_done), .err_pattern(err_pattern)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_total++;
  end

  task automatic set_bus(input logic [3:0] an, input logic [6:0] p);
    {an3, an2, an1, an0} = an;
    {g, f, e, d, c, b, a} = p;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle;
    set_bus(4'hF, 7'h7F);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3,
                      input int dwell, input logic [3:0] mask);
    logic [6:0] pats [4];
    logic [3:0] sel;
    pats = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        sel = 4'b0001 << i;
        set_bus(~sel, pats[i]);
        wait_cycles(dwell);
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    wait_cycles(2);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    bus_idle();
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h10, 5'h10, 5'h10, 5'h10}) begin
      errors++; $display("FAIL reset_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h10, 5'h10, 5'h10, 5'h10});
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++;
    if (err_pattern !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_pattern); end
    rst = 1'b1;
    wait_cycles(4);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", valid); end
  endtask

  task automatic test_scan;
    base = fd_total;
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 1) begin errors++; $display("FAIL scan_pulses: got %0d expected 1", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h01, 5'h00, 5'h03}) begin
      errors++; $display("FAIL scan_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h01, 5'h00, 5'h03});
    end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL scan_valid: got %b expected 1", valid); end
    checks++;
    if (err_pattern !== 1'b0) begin errors++; $display("FAIL scan_err: got %b expected 0", err_pattern); end
  endtask

  task automatic test_two_anodes;
    base = fd_total;
    set_bus(4'b1100, 7'h00);
    wait_cycles(20);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 0) begin errors++; $display("FAIL two_anodes_pulses: got %0d expected 0", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h01, 5'h00, 5'h03}) begin
      errors++; $display("FAIL two_anodes_hold: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h01, 5'h00, 5'h03});
    end
    scan(7'h7F, 7'h7F, 7'h7F, 7'h7F, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 1) begin errors++; $display("FAIL blank_pulses: got %0d expected 1", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h10, 5'h10, 5'h10, 5'h10}) begin
      errors++; $display("FAIL blank_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h10, 5'h10, 5'h10, 5'h10});
    end
  endtask

  task automatic test_back_to_back;
    base = fd_total;
    scan(7'h19, 7'h12, 7'h02, 7'h78, 16, 4'hF);
    scan(7'h08, 7'h03, 7'h46, 7'h21, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h0D, 5'h0C, 5'h0B, 5'h0A}) begin
      errors++; $display("FAIL b2b_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h0D, 5'h0C, 5'h0B, 5'h0A});
    end
    checks++;
    if (err_pattern !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", err_pattern); end
  endtask

  task automatic test_bad_pattern;
    base = fd_total;
    scan(7'h30, 7'h40, 7'h55, 7'h24, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h1F, 5'h00, 5'h03}) begin
      errors++; $display("FAIL bad_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h1F, 5'h00, 5'h03});
    end
    checks++;
    if (err_pattern !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b expected 1", err_pattern); end
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h01, 5'h00, 5'h03}) begin
      errors++; $display("FAIL clean_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h01, 5'h00, 5'h03});
    end
    checks++;
    if (err_pattern !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", err_pattern); end
    checks++;
    if (fd_total - base !== 2) begin errors++; $display("FAIL bad_pulses: got %0d expected 2", fd_total - base); end
    do_reset();
    checks++;
    if (err_pattern !== 1'b0) begin errors++; $display("FAIL bad_err_cleared: got %b expected 0", err_pattern); end
  endtask

  task automatic test_short_dwell;
    do_reset();
    base = fd_total;
    scan(7'h30, 7'h40, 7'h79, 7'h24, 3, 4'hF);
    scan(7'h30, 7'h40, 7'h79, 7'h24, 3, 4'hF);
    bus_idle();
    wait_cycles(4);
    checks++;
    if (fd_total - base !== 0) begin errors++; $display("FAIL short_pulses: got %0d expected 0", fd_total - base); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b expected 0", valid); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h10, 5'h10, 5'h10, 5'h10}) begin
      errors++; $display("FAIL short_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h10, 5'h10, 5'h10, 5'h10});
    end
  endtask

  task automatic test_min_dwell;
    base = fd_total;
    scan(7'h06, 7'h0E, 7'h10, 7'h00, 4, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 1) begin errors++; $display("FAIL min_pulses: got %0d expected 1", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h08, 5'h09, 5'h0F, 5'h0E}) begin
      errors++; $display("FAIL min_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h08, 5'h09, 5'h0F, 5'h0E});
    end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL min_valid: got %b expected 1", valid); end
  endtask

  task automatic test_timeout;
    do_reset();
    base = fd_total;
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'hF);
    // Last capture happened 12 cycles ago; valid must survive until 64.
    bus_idle();
    wait_cycles(52);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL timeout_before: got %b expected 1", valid); end
    wait_cycles(1);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL timeout_after: got %b expected 0", valid); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h01, 5'h00, 5'h03}) begin
      errors++; $display("FAIL timeout_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h01, 5'h00, 5'h03});
    end
    wait_cycles(17);
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL timeout_recover: got %b expected 1", valid); end
    checks++;
    if (fd_total - base !== 2) begin errors++; $display("FAIL timeout_pulses: got %0d expected 2", fd_total - base); end
  endtask

  task automatic test_reset_mid;
    base = fd_total;
    scan(7'h19, 7'h12, 7'h02, 7'h78, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h07, 5'h06, 5'h05, 5'h04}) begin
      errors++; $display("FAIL mid_pre_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h07, 5'h06, 5'h05, 5'h04});
    end
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'b0111);
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h10, 5'h10, 5'h10, 5'h10}) begin
      errors++; $display("FAIL mid_rst_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h10, 5'h10, 5'h10, 5'h10});
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_done: got %b expected 0", frame_done); end
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'b1000);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 1) begin errors++; $display("FAIL mid_partial_pulses: got %0d expected 1", fd_total - base); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_partial_valid: got %b expected 0", valid); end
    scan(7'h30, 7'h40, 7'h79, 7'h24, 16, 4'hF);
    bus_idle();
    wait_cycles(2);
    checks++;
    if (fd_total - base !== 2) begin errors++; $display("FAIL mid_full_pulses: got %0d expected 2", fd_total - base); end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== {5'h02, 5'h01, 5'h00, 5'h03}) begin
      errors++; $display("FAIL mid_full_digits: got %h expected %h", {digit3, digit2, digit1, digit0}, {5'h02, 5'h01, 5'h00, 5'h03});
    end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b expected 1", valid); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_scan();
    test_two_anodes();
    test_back_to_back();
    test_bad_pattern();
    test_short_dwell();
    test_min_dwell();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles the segment/anode bus must be unchanged before a digit is sampled (range 2..255).
REQ-002 Parameter TIMEOUT, default 1048576: cycles without any capture before the valid output drops.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (rst=0 resets on the next clk edge).
REQ-005 a,b,c,d,e,f,g  input  1 each  multiplexed segment lines, active-low (0 = lit).
REQ-006 an0,an1,an2,an3  input  1 each  digit anode enables, active-low (0 = digit selected).
REQ-007 digit0..digit3  output  5 each  last published decoded code per digit.
REQ-008 valid  output  1  published digits are from a frame completed within TIMEOUT.
REQ-009 frame_done  output  1  one-cycle pulse when a new frame is published.
REQ-010 err_pattern  output  1  sticky flag: an undecodable segment pattern was captured.

Function
REQ-011 Segment pattern P = {g,f,e,d,c,b,a}; input bus W = {an3,an2,an1,an0,P}, registered once before any use.
REQ-012 Decode P (hex): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F, 7F->5'h10 (blank), 3F->5'h11 (dash); any other P->5'h1F.
REQ-013 Stability counter: reset to 0 when registered W differs from its previous value, else increments, saturating at SETTLE.
REQ-014 FSM states SETTLING and HELD; reset state SETTLING.
REQ-015 SETTLING: when counter reaches SETTLE-1 with unchanged W and exactly one anode low (index k), store decoded code in shadow[k], set seen[k], go HELD.
REQ-016 SETTLING with zero or more than one anode low: no capture, remain SETTLING.
REQ-017 HELD: remain until W changes, then go SETTLING; at most one capture per dwell.
REQ-018 Re-capture of an already-seen digit overwrites shadow[k]; seen[k] stays 1.
REQ-019 When seen becomes 4'b1111: on the next edge copy shadow[0..3] to digit0..3, pulse frame_done for one cycle, set valid, clear seen.
REQ-020 Capture and publish in the same cycle: publish uses shadow as it stood before that capture; the new capture sets seen for the next frame.
REQ-021 Capture of a 5'h1F code sets err_pattern; only reset clears it.
REQ-022 Idle counter: clears on every capture, else increments saturating at TIMEOUT; on reaching TIMEOUT valid clears; digits hold their values.
REQ-023 Latency: W stable from cycle t -> capture at edge t+SETTLE (one input register stage); publish one edge after the fourth distinct digit capture.

Reset
REQ-024 rst=0 at a clk edge: digit0..3=5'h10, valid=0, frame_done=0, err_pattern=0, seen=0, shadow=5'h10, counters=0, state=SETTLING.
REQ-025 Reset asserted mid-frame discards partial captures; after release, the first frame needs all four digits re-captured.

Verification
REQ-026 Scan digits 3,0,1,2 as an-index 0..3 with patterns 30,40,79,24, dwell 16 cycles each, SETTLE=4 -> frame_done pulse once, digit0..3=3,0,1,2, valid=1, err_pattern=0.
REQ-027 Dwell of SETTLE-1 cycles per digit -> no captures, frame_done never pulses, valid stays 0.
REQ-028 an3..an0=4'b1100 (two anodes low) held 20 cycles with P=00 -> no capture; then a normal scan with P=7F on all digits -> all digits 5'h10.
REQ-029 Digit 2 pattern 55 in an otherwise valid scan -> digit2=5'h1F, err_pattern=1 and remains 1 through subsequent clean frames until rst=0.
REQ-030 TIMEOUT=64: one full frame then all anodes high for 70 cycles -> valid falls 64 cycles after the last capture, digits unchanged; next full frame -> valid=1.
REQ-031 rst=0 for one edge after three of four digits captured -> all outputs at reset values; publish only after all four digits are scanned again.
